// File: rtl/axi_arbiter_2to1_if.sv
// AXI4 channel bundle used for both upstream requesters and the shared downstream port.
// Every channel transfers on a rising clk edge where valid and ready are both high; a source holds valid and payload until then.
interface axi_channel #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1
);
    logic                    aw_valid, aw_ready;
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size, aw_prot;
    logic [1:0]              aw_burst;
    logic [USER_WIDTH-1:0]   aw_user;

    logic                    w_valid, w_ready, w_last;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic [USER_WIDTH-1:0]   w_user;

    logic                    b_valid, b_ready;
    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic [USER_WIDTH-1:0]   b_user;

    logic                    ar_valid, ar_ready;
    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size, ar_prot;
    logic [1:0]              ar_burst;
    logic [USER_WIDTH-1:0]   ar_user;

    logic                    r_valid, r_ready, r_last;
    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic [USER_WIDTH-1:0]   r_user;

    modport master (
        output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_prot, aw_user,
        output w_valid, w_data, w_strb, w_last, w_user, b_ready,
        output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_prot, ar_user, r_ready,
        input  aw_ready, w_ready, b_valid, b_id, b_resp, b_user,
        input  ar_ready, r_valid, r_id, r_data, r_resp, r_last, r_user
    );

    modport slave (
        input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_prot, aw_user,
        input  w_valid, w_data, w_strb, w_last, w_user, b_ready,
        input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_prot, ar_user, r_ready,
        output aw_ready, w_ready, b_valid, b_id, b_resp, b_user,
        output ar_ready, r_valid, r_id, r_data, r_resp, r_last, r_user
    );
endinterface

// File: rtl/axi_arbiter_2to1.sv
// Two-master to one-slave AXI4 arbiter: round-robin AW and AR arbitration, W locked to the
// granted writer until w_last, B/R routed back on the ID bit prepended to the downstream ID.
module axi_arbiter_2to1 #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1
) (
    input  logic       clk,
    input  logic       rstn,
    axi_channel.slave  master0,
    axi_channel.slave  master1,
    axi_channel.master slave,
    output logic [1:0] dbg_w_state,
    output logic       dbg_r_state
);
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2} w_state_e;
    typedef enum logic {R_IDLE = 1'b0, R_ADDR = 1'b1} r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;
    logic     wsel_q, wsel_d, wprio_q, wprio_d;
    logic     rsel_q, rsel_d, rprio_q, rprio_d;

    logic                  aw_req_sel, w_valid_sel, w_last_sel, ar_req_sel;
    logic                  aw_hs, w_last_hs, ar_hs;
    logic [ADDR_WIDTH-1:0] aw_addr_sel, ar_addr_sel;
    logic [DATA_WIDTH-1:0] w_data_sel;
    logic [USER_WIDTH-1:0] w_user_sel;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            wsel_q    <= 1'b0;
            wprio_q   <= 1'b0;
            rsel_q    <= 1'b0;
            rprio_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            wsel_q    <= wsel_d;
            wprio_q   <= wprio_d;
            rsel_q    <= rsel_d;
            rprio_q   <= rprio_d;
        end
    end

    assign aw_req_sel  = wsel_q ? master1.aw_valid : master0.aw_valid;
    assign w_valid_sel = wsel_q ? master1.w_valid  : master0.w_valid;
    assign w_last_sel  = wsel_q ? master1.w_last   : master0.w_last;
    assign ar_req_sel  = rsel_q ? master1.ar_valid : master0.ar_valid;

    assign aw_hs     = (w_state_q == W_ADDR) && aw_req_sel && slave.aw_ready;
    assign w_last_hs = (w_state_q == W_DATA) && w_valid_sel && w_last_sel && slave.w_ready;
    assign ar_hs     = (r_state_q == R_ADDR) && ar_req_sel && slave.ar_ready;

    // A lone requester wins outright; on a tie the round-robin pointer decides.
    always_comb begin
        w_state_d = w_state_q;
        wsel_d    = wsel_q;
        wprio_d   = wprio_q;
        case (w_state_q)
            W_IDLE: begin
                if (master0.aw_valid || master1.aw_valid) begin
                    wsel_d    = (master0.aw_valid && master1.aw_valid) ? wprio_q : master1.aw_valid;
                    w_state_d = W_ADDR;
                end
            end
            W_ADDR: if (aw_hs) w_state_d = W_DATA;
            W_DATA: begin
                if (w_last_hs) begin
                    w_state_d = W_IDLE;
                    wprio_d   = ~wsel_q;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        rsel_d    = rsel_q;
        rprio_d   = rprio_q;
        case (r_state_q)
            R_IDLE: begin
                if (master0.ar_valid || master1.ar_valid) begin
                    rsel_d    = (master0.ar_valid && master1.ar_valid) ? rprio_q : master1.ar_valid;
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (ar_hs) begin
                    r_state_d = R_IDLE;
                    rprio_d   = ~rsel_q;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign aw_addr_sel = wsel_q ? master1.aw_addr : master0.aw_addr;
    assign ar_addr_sel = rsel_q ? master1.ar_addr : master0.ar_addr;
    assign w_data_sel  = wsel_q ? master1.w_data  : master0.w_data;
    assign w_user_sel  = wsel_q ? master1.w_user  : master0.w_user;

    assign slave.aw_valid = (w_state_q == W_ADDR) && aw_req_sel;
    assign slave.aw_id    = {wsel_q, wsel_q ? master1.aw_id : master0.aw_id};
    assign slave.aw_addr  = aw_addr_sel;
    assign slave.aw_len   = wsel_q ? master1.aw_len   : master0.aw_len;
    assign slave.aw_size  = wsel_q ? master1.aw_size  : master0.aw_size;
    assign slave.aw_burst = wsel_q ? master1.aw_burst : master0.aw_burst;
    assign slave.aw_prot  = wsel_q ? master1.aw_prot  : master0.aw_prot;
    assign slave.aw_user  = wsel_q ? master1.aw_user  : master0.aw_user;
    assign master0.aw_ready = (w_state_q == W_ADDR) && !wsel_q && slave.aw_ready;
    assign master1.aw_ready = (w_state_q == W_ADDR) &&  wsel_q && slave.aw_ready;

    // W from the ungranted master, even if presented early, sees w_ready low.
    assign slave.w_valid  = (w_state_q == W_DATA) && w_valid_sel;
    assign slave.w_data   = w_data_sel;
    assign slave.w_strb   = wsel_q ? master1.w_strb : master0.w_strb;
    assign slave.w_last   = w_last_sel;
    assign slave.w_user   = w_user_sel;
    assign master0.w_ready = (w_state_q == W_DATA) && !wsel_q && slave.w_ready;
    assign master1.w_ready = (w_state_q == W_DATA) &&  wsel_q && slave.w_ready;

    assign slave.ar_valid = (r_state_q == R_ADDR) && ar_req_sel;
    assign slave.ar_id    = {rsel_q, rsel_q ? master1.ar_id : master0.ar_id};
    assign slave.ar_addr  = ar_addr_sel;
    assign slave.ar_len   = rsel_q ? master1.ar_len   : master0.ar_len;
    assign slave.ar_size  = rsel_q ? master1.ar_size  : master0.ar_size;
    assign slave.ar_burst = rsel_q ? master1.ar_burst : master0.ar_burst;
    assign slave.ar_prot  = rsel_q ? master1.ar_prot  : master0.ar_prot;
    assign slave.ar_user  = rsel_q ? master1.ar_user  : master0.ar_user;
    assign master0.ar_ready = (r_state_q == R_ADDR) && !rsel_q && slave.ar_ready;
    assign master1.ar_ready = (r_state_q == R_ADDR) &&  rsel_q && slave.ar_ready;

    // Responses are steered purely by the prepended ID bit, with no state.
    assign master0.b_valid = slave.b_valid && !slave.b_id[ID_WIDTH];
    assign master1.b_valid = slave.b_valid &&  slave.b_id[ID_WIDTH];
    assign master0.b_id    = slave.b_id[ID_WIDTH-1:0];
    assign master1.b_id    = slave.b_id[ID_WIDTH-1:0];
    assign master0.b_resp  = slave.b_resp;
    assign master1.b_resp  = slave.b_resp;
    assign master0.b_user  = slave.b_user;
    assign master1.b_user  = slave.b_user;
    assign slave.b_ready   = slave.b_id[ID_WIDTH] ? master1.b_ready : master0.b_ready;

    assign master0.r_valid = slave.r_valid && !slave.r_id[ID_WIDTH];
    assign master1.r_valid = slave.r_valid &&  slave.r_id[ID_WIDTH];
    assign master0.r_id    = slave.r_id[ID_WIDTH-1:0];
    assign master1.r_id    = slave.r_id[ID_WIDTH-1:0];
    assign master0.r_data  = slave.r_data;
    assign master1.r_data  = slave.r_data;
    assign master0.r_resp  = slave.r_resp;
    assign master1.r_resp  = slave.r_resp;
    assign master0.r_last  = slave.r_last;
    assign master1.r_last  = slave.r_last;
    assign master0.r_user  = slave.r_user;
    assign master1.r_user  = slave.r_user;
    assign slave.r_ready   = slave.r_id[ID_WIDTH] ? master1.r_ready : master0.r_ready;

    assign dbg_w_state = w_state_q;
    assign dbg_r_state = r_state_q;
endmodule

// File: tb/tb_axi_arbiter_2to1.sv
// Randomized and directed bench for axi_arbiter_2to1 with a transaction-level scoreboard.
module tb_axi_arbiter_2to1;
  localparam int IW = 4;
  localparam int AW = 48;
  localparam int DW = 64;
  localparam int UW = 1;
  localparam int AWW = IW + AW + 8 + UW;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [1:0] dbg_w_state;
  logic dbg_r_state;

  always #5 clk = ~clk;

  axi_channel #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) m0_if ();
  axi_channel #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) m1_if ();
  axi_channel #(.ID_WIDTH(IW+1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) s_if ();

  axi_arbiter_2to1 #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
    .clk(clk), .rstn(rstn), .master0(m0_if), .master1(m1_if), .slave(s_if),
    .dbg_w_state(dbg_w_state), .dbg_r_state(dbg_r_state)
  );

  int n_tests = 0;
  int n_fail = 0;

  // Master-side send queues and the scoreboard's expected queues, per master.
  logic [AWW-1:0] aw_send [2][$];
  logic [AWW-1:0] ar_send [2][$];
  logic [DW:0]    w_send  [2][$];
  logic [AWW-1:0] exp_aw  [2][$];
  logic [AWW-1:0] exp_ar  [2][$];
  logic [DW:0]    exp_w   [2][$];
  int w_owner[$];
  int ev_q[$];
  int ar_log[$];
  int ar_cyc[$];
  int cyc = 0;
  int wbeats = 0;
  int aw_rdy_pct = 100, w_rdy_pct = 100, ar_rdy_pct = 100;
  bit resp_en = 0;
  bit b_hs = 0, r_hs = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic enqueue_write(input int m, input logic [3:0] id, input logic [7:0] len);
    logic [AWW-1:0] a;
    a = {id, 48'({$urandom, $urandom}), len, 1'($urandom)};
    aw_send[m].push_back(a);
    exp_aw[m].push_back(a);
    for (int k = 0; k <= int'(len); k++) begin
      logic [DW:0] b;
      b = {k == int'(len), $urandom, $urandom};
      w_send[m].push_back(b);
      exp_w[m].push_back(b);
    end
  endtask

  task automatic enqueue_read(input int m, input logic [3:0] id);
    logic [AWW-1:0] a;
    a = {id, 48'({$urandom, $urandom}), 8'($urandom_range(0, 15)), 1'($urandom)};
    ar_send[m].push_back(a);
    exp_ar[m].push_back(a);
  endtask

  task automatic flush();
    for (int m = 0; m < 2; m++) begin
      aw_send[m].delete(); ar_send[m].delete(); w_send[m].delete();
      exp_aw[m].delete(); exp_ar[m].delete(); exp_w[m].delete();
    end
    w_owner.delete();
    m0_if.aw_valid = 0; m0_if.w_valid = 0; m0_if.ar_valid = 0;
    m1_if.aw_valid = 0; m1_if.w_valid = 0; m1_if.ar_valid = 0;
    s_if.b_valid = 0; s_if.r_valid = 0;
    b_hs = 0; r_hs = 0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    flush();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  function automatic bit busy();
    int n;
    n = w_owner.size();
    for (int m = 0; m < 2; m++)
      n += aw_send[m].size() + ar_send[m].size() + w_send[m].size()
         + exp_aw[m].size() + exp_ar[m].size() + exp_w[m].size();
    return n != 0;
  endfunction

  // One bus cycle: drive at the falling edge, evaluate what the next rising edge will transfer.
  task automatic step();
    int o;
    logic [DW:0] e;
    @(negedge clk);
    m0_if.aw_valid = aw_send[0].size() != 0;
    if (aw_send[0].size() != 0) {m0_if.aw_id, m0_if.aw_addr, m0_if.aw_len, m0_if.aw_user} = aw_send[0][0];
    m1_if.aw_valid = aw_send[1].size() != 0;
    if (aw_send[1].size() != 0) {m1_if.aw_id, m1_if.aw_addr, m1_if.aw_len, m1_if.aw_user} = aw_send[1][0];
    m0_if.w_valid = w_send[0].size() != 0;
    if (w_send[0].size() != 0) {m0_if.w_last, m0_if.w_data} = w_send[0][0];
    m1_if.w_valid = w_send[1].size() != 0;
    if (w_send[1].size() != 0) {m1_if.w_last, m1_if.w_data} = w_send[1][0];
    m0_if.ar_valid = ar_send[0].size() != 0;
    if (ar_send[0].size() != 0) {m0_if.ar_id, m0_if.ar_addr, m0_if.ar_len, m0_if.ar_user} = ar_send[0][0];
    m1_if.ar_valid = ar_send[1].size() != 0;
    if (ar_send[1].size() != 0) {m1_if.ar_id, m1_if.ar_addr, m1_if.ar_len, m1_if.ar_user} = ar_send[1][0];
    s_if.aw_ready = $urandom_range(0, 99) < aw_rdy_pct;
    s_if.w_ready  = $urandom_range(0, 99) < w_rdy_pct;
    s_if.ar_ready = $urandom_range(0, 99) < ar_rdy_pct;
    if (resp_en) begin
      if (!s_if.b_valid || b_hs) begin
        s_if.b_valid = 1'($urandom); s_if.b_id = 5'($urandom);
        s_if.b_resp = 2'($urandom); s_if.b_user = 1'($urandom);
      end
      if (!s_if.r_valid || r_hs) begin
        s_if.r_valid = 1'($urandom); s_if.r_id = 5'($urandom); s_if.r_data = {$urandom, $urandom};
        s_if.r_last = 1'($urandom); s_if.r_resp = 2'($urandom); s_if.r_user = 1'($urandom);
      end
      m0_if.b_ready = 1'($urandom); m1_if.b_ready = 1'($urandom);
      m0_if.r_ready = 1'($urandom); m1_if.r_ready = 1'($urandom);
    end
    #1;
    // Response steering, keyed on the ID bit the slave model chose.
    check("b_valid_m0", m0_if.b_valid, s_if.b_valid && !s_if.b_id[IW]);
    check("b_valid_m1", m1_if.b_valid, s_if.b_valid && s_if.b_id[IW]);
    check("r_valid_m0", m0_if.r_valid, s_if.r_valid && !s_if.r_id[IW]);
    check("r_valid_m1", m1_if.r_valid, s_if.r_valid && s_if.r_id[IW]);
    if (s_if.b_valid) begin
      check("b_id", s_if.b_id[IW] ? m1_if.b_id : m0_if.b_id, s_if.b_id[IW-1:0]);
      check("b_ready", s_if.b_ready, s_if.b_id[IW] ? m1_if.b_ready : m0_if.b_ready);
    end
    if (s_if.r_valid) begin
      check("r_id", s_if.r_id[IW] ? m1_if.r_id : m0_if.r_id, s_if.r_id[IW-1:0]);
      check("r_data", s_if.r_id[IW] ? m1_if.r_data : m0_if.r_data, s_if.r_data);
      check("r_ready", s_if.r_ready, s_if.r_id[IW] ? m1_if.r_ready : m0_if.r_ready);
    end
    o = (w_owner.size() != 0) ? w_owner[0] : -1;
    if (o != 0) check("w_ready_m0_unowned", m0_if.w_ready, 0);
    if (o != 1) check("w_ready_m1_unowned", m1_if.w_ready, 0);
    b_hs = s_if.b_valid && s_if.b_ready;
    r_hs = s_if.r_valid && s_if.r_ready;
    if (m0_if.aw_valid && m0_if.aw_ready) void'(aw_send[0].pop_front());
    if (m1_if.aw_valid && m1_if.aw_ready) void'(aw_send[1].pop_front());
    if (m0_if.w_valid && m0_if.w_ready) void'(w_send[0].pop_front());
    if (m1_if.w_valid && m1_if.w_ready) void'(w_send[1].pop_front());
    if (m0_if.ar_valid && m0_if.ar_ready) void'(ar_send[0].pop_front());
    if (m1_if.ar_valid && m1_if.ar_ready) void'(ar_send[1].pop_front());
    if (s_if.aw_valid && s_if.aw_ready) begin
      int m;
      m = int'(s_if.aw_id[IW]);
      ev_q.push_back(100 + int'(s_if.aw_id));
      check("aw_expected", exp_aw[m].size() != 0, 1);
      if (exp_aw[m].size() != 0)
        check("aw_fields", {s_if.aw_id[IW-1:0], s_if.aw_addr, s_if.aw_len, s_if.aw_user}, exp_aw[m].pop_front());
      w_owner.push_back(m);
    end
    if (s_if.w_valid && s_if.w_ready) begin
      ev_q.push_back(1);
      wbeats++;
      check("w_has_owner", w_owner.size() != 0, 1);
      if (w_owner.size() != 0) begin
        check("w_expected", exp_w[w_owner[0]].size() != 0, 1);
        if (exp_w[w_owner[0]].size() != 0) begin
          e = exp_w[w_owner[0]].pop_front();
          check("w_data", s_if.w_data, e[DW-1:0]);
          check("w_last", s_if.w_last, e[DW]);
          if (e[DW]) void'(w_owner.pop_front());
        end
      end
    end
    if (s_if.ar_valid && s_if.ar_ready) begin
      int m;
      m = int'(s_if.ar_id[IW]);
      ar_log.push_back(m);
      ar_cyc.push_back(cyc);
      check("ar_expected", exp_ar[m].size() != 0, 1);
      if (exp_ar[m].size() != 0)
        check("ar_fields", {s_if.ar_id[IW-1:0], s_if.ar_addr, s_if.ar_len, s_if.ar_user}, exp_ar[m].pop_front());
    end
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", busy(), 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_slave_valids"}, {s_if.aw_valid, s_if.w_valid, s_if.ar_valid}, 0);
    check({tag, "_m_readies"}, {m0_if.aw_ready, m0_if.w_ready, m0_if.ar_ready,
                               m1_if.aw_ready, m1_if.w_ready, m1_if.ar_ready}, 0);
    check({tag, "_fsm_idle"}, {dbg_w_state, dbg_r_state}, 0);
  endtask

  initial begin
    int budget;
    int n0;
    int exp_ev[10] = '{102, 1, 1, 1, 1, 118, 1, 1, 1, 1};
    m0_if.aw_size = 3'd3; m0_if.aw_burst = 2'd1; m0_if.aw_prot = 3'd0; m0_if.w_strb = '1; m0_if.w_user = 1'b0;
    m0_if.ar_size = 3'd3; m0_if.ar_burst = 2'd1; m0_if.ar_prot = 3'd0;
    m1_if.aw_size = 3'd3; m1_if.aw_burst = 2'd1; m1_if.aw_prot = 3'd0; m1_if.w_strb = '1; m1_if.w_user = 1'b1;
    m1_if.ar_size = 3'd3; m1_if.ar_burst = 2'd1; m1_if.ar_prot = 3'd0;
    m0_if.b_ready = 0; m1_if.b_ready = 0; m0_if.r_ready = 0; m1_if.r_ready = 0;
    s_if.aw_ready = 1; s_if.w_ready = 1; s_if.ar_ready = 1;
    s_if.b_id = '0; s_if.b_resp = '0; s_if.b_user = '0;
    s_if.r_id = '0; s_if.r_data = '0; s_if.r_resp = '0; s_if.r_last = 0; s_if.r_user = '0;
    flush();

    // Reset: requests asserted while in reset must not be granted.
    @(negedge clk);
    m0_if.aw_valid = 1; m1_if.ar_valid = 1;
    #1 check_quiet("in_reset");
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      check_quiet("idle_after_reset");
    end

    // Simultaneous writes: m0 wins on the reset pointer, then m1 follows.
    ev_q.delete();
    enqueue_write(0, 4'h2, 8'd3);
    enqueue_write(1, 4'h2, 8'd3);
    step();
    check("aw_latency_cycle0", s_if.aw_valid, 0);
    step();
    check("aw_latency_cycle1", s_if.aw_valid, 1);
    check("aw_first_id", s_if.aw_id, 5'h02);
    drain(100);
    check("sim_write_event_count", ev_q.size(), 10);
    for (int i = 0; i < 10 && i < ev_q.size(); i++) check("sim_write_order", ev_q[i], exp_ev[i]);

    // Read fairness: both masters keep ar_valid high.
    do_reset();
    ar_log.delete(); ar_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      enqueue_read(0, 4'($urandom));
      enqueue_read(1, 4'($urandom));
    end
    drain(100);
    n0 = 0;
    for (int i = 0; i < 8 && i < ar_log.size(); i++) begin
      check("ar_alternate", ar_log[i], i % 2);
      if (ar_log[i] == 0) n0++;
      if (i > 0) check("ar_issue_gap", ar_cyc[i] - ar_cyc[i-1], 2);
    end
    check("ar_m0_grants", n0, 4);

    // Response routing with explicit values.
    step();
    s_if.r_valid = 1; s_if.r_id = 5'h13; s_if.r_last = 1; s_if.r_data = 64'hDEAD_BEEF_0123_4567;
    m0_if.r_ready = 1; m1_if.r_ready = 0;
    #1;
    check("r_route_m1_valid", m1_if.r_valid, 1);
    check("r_route_m0_valid", m0_if.r_valid, 0);
    check("r_route_id", m1_if.r_id, 4'h3);
    check("r_route_last", m1_if.r_last, 1);
    check("r_backpressure", s_if.r_ready, 0);
    s_if.b_valid = 1; s_if.b_id = 5'h05; m0_if.b_ready = 1; m1_if.b_ready = 0;
    #1;
    check("b_route_m0_valid", m0_if.b_valid, 1);
    check("b_route_m1_valid", m1_if.b_valid, 0);
    check("b_route_id", m0_if.b_id, 4'h5);
    check("b_route_ready", s_if.b_ready, 1);
    s_if.r_valid = 0; s_if.b_valid = 0;

    // Early W from m1 while m0 bursts.
    do_reset();
    enqueue_write(0, 4'h1, 8'd3);
    step(); step();
    enqueue_write(1, 4'h6, 8'd2);
    budget = 0;
    do begin
      step();
      check("early_w_ready_m1", m1_if.w_ready, 0);
      budget++;
    end while (aw_send[1].size() != 0 && budget < 50);
    drain(100);

    // Reset during beat 2 of a 4-beat write.
    do_reset();
    wbeats = 0;
    enqueue_write(0, 4'h4, 8'd3);
    budget = 0;
    while (wbeats < 1 && budget < 50) begin
      step();
      budget++;
    end
    step();
    check("beat2_presented", s_if.w_valid, 1);
    rstn = 1'b0;
    #1;
    check("reset_drops_w_valid", s_if.w_valid, 0);
    check_quiet("mid_burst_reset");
    flush();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    enqueue_write(1, 4'h7, 8'd1);
    step();
    check("post_reset_aw_cycle0", s_if.aw_valid, 0);
    step();
    check("post_reset_aw_cycle1", s_if.aw_valid, 1);
    check("post_reset_aw_id", s_if.aw_id, 5'h17);
    drain(100);

    // Randomized traffic with backpressure and random responses.
    do_reset();
    resp_en = 1;
    aw_rdy_pct = $urandom_range(30, 100);
    w_rdy_pct = $urandom_range(30, 100);
    ar_rdy_pct = $urandom_range(30, 100);
    for (int c = 0; c < 3000; c++) begin
      int m;
      m = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0 && aw_send[m].size() < 4)
        enqueue_write(m, 4'($urandom), 8'($urandom_range(0, 7)));
      m = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0 && ar_send[m].size() < 4)
        enqueue_read(m, 4'($urandom));
      step();
    end
    drain(3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
